pq_dispatcher: RTL and testbench

PQ_DISPATCHER -- requirements
Module: pq_dispatcher

---
 rtl/pq_dispatcher.sv | 115 +++++++++++
 tb/tb_pq_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_dispatcher.sv
// Event dispatcher in front of an external min-priority queue: one queue operation per IDLE cycle, round-robin enqueue/dequeue.
// Optional PQ_DISP_BYPASS_EN: with the queue and output register empty, an event goes straight to the output register.
module pq_dispatcher #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_in_valid,
  input  logic [DWIDTH-1:0] ev_in_data,
  output logic              ev_in_ready,
  output logic              ev_out_valid,
  output logic [DWIDTH-1:0] ev_out_data,
  input  logic              ev_out_ready,
  output logic              q_enq,
  output logic              q_deq,
  output logic [DWIDTH-1:0] q_inp_data,
  input  logic [DWIDTH-1:0] q_out_data,
  input  logic              q_full,
  input  logic              q_empty,
  input  logic              q_ready,
  input  logic [CWIDTH-1:0] q_elem_cnt,
  output logic [15:0]       enq_total,
  output logic [15:0]       deq_total,
  output logic              err_causal,
  output logic              dbg_state,
  output logic [CWIDTH-1:0] dbg_peak_cnt
);

  // Handshakes: a word moves on ev_in_valid & ev_in_ready and on ev_out_valid & ev_out_ready;
  // ev_in_ready never looks at ev_in_valid, and ev_out_valid/ev_out_data hold until taken.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_nxt;
  logic rr;
  logic [DWIDTH-1:0] last_disp;
  logic deq_ok, enq_ok, byp_rdy, in_rdy;
  logic enq_fire, deq_fire, byp_fire;

  always_comb begin
    state_nxt = state;
    deq_ok    = 1'b0;
    enq_ok    = 1'b0;
    byp_rdy   = 1'b0;
    in_rdy    = 1'b0;
    enq_fire  = 1'b0;
    deq_fire  = 1'b0;
    byp_fire  = 1'b0;
    case (state)
      IDLE: begin
        deq_ok = q_ready & ~q_empty & ~ev_out_valid;
        enq_ok = q_ready & ~q_full;
`ifdef PQ_DISP_BYPASS_EN
        byp_rdy = q_empty & ~ev_out_valid;
`else
        byp_rdy = 1'b0;
`endif
        // rr=1 means the last operation was an enqueue, so a pending dequeue wins now
        in_rdy   = byp_rdy | (enq_ok & ~(deq_ok & rr));
        byp_fire = ev_in_valid & byp_rdy;
        enq_fire = ev_in_valid & in_rdy & ~byp_rdy;
        deq_fire = deq_ok & ~enq_fire;
        if (enq_fire | deq_fire) state_nxt = WAIT;
      end
      WAIT: begin
        if (q_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are forced low for as long as reset is held
  assign ev_in_ready = in_rdy & ~rst_n;
  assign q_enq       = enq_fire & ~rst_n;
  assign q_deq       = deq_fire & ~rst_n;
  assign q_inp_data  = q_enq ? ev_in_data : '0;
  assign dbg_state   = (state == WAIT);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      ev_out_valid <= 1'b0;
      ev_out_data  <= '0;
      last_disp    <= '0;
      err_causal   <= 1'b0;
      enq_total    <= '0;
      deq_total    <= '0;
      dbg_peak_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (enq_fire) rr <= 1'b1;
      else if (deq_fire) rr <= 1'b0;

      if (deq_fire) begin
        ev_out_valid <= 1'b1;
        ev_out_data  <= q_out_data;
        last_disp    <= q_out_data;
      end else if (byp_fire) begin
        ev_out_valid <= 1'b1;
        ev_out_data  <= ev_in_data;
        last_disp    <= ev_in_data;
      end else if (ev_out_valid & ev_out_ready) begin
        ev_out_valid <= 1'b0;
      end

      // An event older than the last dispatched one breaks time order
      if (enq_fire && (ev_in_data < last_disp)) err_causal <= 1'b1;
      if (enq_fire) enq_total <= enq_total + 16'd1;
      if (deq_fire) deq_total <= deq_total + 16'd1;
      if (q_elem_cnt > dbg_peak_cnt) dbg_peak_cnt <= q_elem_cnt;
    end
  end

endmodule

// File: tb/tb_pq_dispatcher.sv
// Bench for pq_dispatcher: behavioural priority queue plus a reference model of the dispatch rules,
// directed scenarios followed by randomized traffic.
module tb_pq_dispatcher;
  localparam int DW  = 32;
  localparam int CW  = 6;
  localparam int CAP = 8;
`ifdef PQ_DISP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          ev_in_valid = 1'b0;
  logic [DW-1:0] ev_in_data = '0;
  logic          ev_out_ready = 1'b0;
  logic [DW-1:0] q_out_data = '0;
  logic          q_full = 1'b0;
  logic          q_empty = 1'b1;
  logic          q_ready = 1'b0;
  logic [CW-1:0] q_elem_cnt = '0;
  logic          ev_in_ready, ev_out_valid, q_enq, q_deq, err_causal, dbg_state;
  logic [DW-1:0] ev_out_data, q_inp_data;
  logic [15:0]   enq_total, deq_total;
  logic [CW-1:0] dbg_peak_cnt;

  pq_dispatcher #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_in_valid(ev_in_valid), .ev_in_data(ev_in_data), .ev_in_ready(ev_in_ready),
    .ev_out_valid(ev_out_valid), .ev_out_data(ev_out_data), .ev_out_ready(ev_out_ready),
    .q_enq(q_enq), .q_deq(q_deq), .q_inp_data(q_inp_data), .q_out_data(q_out_data),
    .q_full(q_full), .q_empty(q_empty), .q_ready(q_ready), .q_elem_cnt(q_elem_cnt),
    .enq_total(enq_total), .deq_total(deq_total), .err_causal(err_causal),
    .dbg_state(dbg_state), .dbg_peak_cnt(dbg_peak_cnt)
  );

  // scoreboard
  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model state
  logic [DW-1:0] pq[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dut_got[$];
  bit            free, last_enq, held_v, err_m, force_full;
  logic [DW-1:0] held_d, last_disp;
  logic [15:0]   n_enq, n_deq;
  logic [CW-1:0] peak;
  int            vp, rp, qp, cyc, since_op, t_acc, t_val, n_enq_seen;

  function automatic int min_idx();
    int k = 0;
    for (int i = 1; i < pq.size(); i++) if (pq[i] < pq[k]) k = i;
    return k;
  endfunction

  function automatic bit all_idle();
    return (src_q.size() == 0) && (pq.size() == 0) && !held_v;
  endfunction

  task automatic model_reset();
    pq.delete(); src_q.delete(); exp_q.delete(); dut_got.delete();
    free = 1'b1; last_enq = 1'b0; held_v = 1'b0; err_m = 1'b0; force_full = 1'b0;
    held_d = '0; last_disp = '0; n_enq = '0; n_deq = '0; peak = '0;
    since_op = 2; t_acc = -1; t_val = -1; n_enq_seen = 0;
  endtask

  // driver: producer, consumer and the behavioural queue's status pins
  task automatic drive();
    ev_in_valid  = (src_q.size() > 0) && ($urandom_range(1, 100) <= vp);
    ev_in_data   = (src_q.size() > 0) ? src_q[0] : '0;
    ev_out_ready = ($urandom_range(1, 100) <= rp);
    q_ready      = ($urandom_range(1, 100) <= qp);
    q_empty      = (pq.size() == 0);
    q_full       = force_full || (pq.size() == CAP);
    q_elem_cnt   = CW'(pq.size());
    q_out_data   = (pq.size() > 0) ? pq[min_idx()] : '0;
  endtask

  // Checks one cycle against the dispatch rules, then advances the model across the coming edge
  task automatic eval();
    bit empty, byp_rdy, can_deq, can_enq, exp_rdy, byp, enq, deq;
    int k;
    empty   = (pq.size() == 0);
    byp_rdy = BYP && free && empty && !held_v;
    can_deq = free && q_ready && !empty && !held_v;
    can_enq = free && q_ready && !q_full;
    exp_rdy = byp_rdy || (can_enq && !(can_deq && last_enq));
    byp     = ev_in_valid && byp_rdy;
    enq     = ev_in_valid && exp_rdy && !byp;
    deq     = can_deq && !enq;

    check_eq("ev_in_ready", DW'(ev_in_ready), DW'(exp_rdy));
    check_eq("q_enq", DW'(q_enq), DW'(enq));
    check_eq("q_deq", DW'(q_deq), DW'(deq));
    check_eq("q_inp_data", q_inp_data, enq ? ev_in_data : '0);
    check_eq("ev_out_valid", DW'(ev_out_valid), DW'(held_v));
    check_eq("ev_out_data", ev_out_data, held_d);
    check_eq("enq_total", DW'(enq_total), DW'(n_enq));
    check_eq("deq_total", DW'(deq_total), DW'(n_deq));
    check_eq("err_causal", DW'(err_causal), DW'(err_m));
    check_eq("dbg_state", DW'(dbg_state), DW'(!free));
    check_eq("dbg_peak_cnt", DW'(dbg_peak_cnt), DW'(peak));
    check_eq("op_excl", DW'(q_enq & q_deq), '0);
    if (q_enq || q_deq) begin
      check_eq("op_gap", DW'(since_op >= 2), DW'(1));
      since_op = 1;
    end else begin
      since_op++;
    end
    if (t_acc < 0 && ev_in_valid && ev_in_ready) t_acc = cyc;
    if (t_val < 0 && ev_out_valid) t_val = cyc;
    if (q_enq) n_enq_seen++;
    if (ev_out_valid && ev_out_ready) dut_got.push_back(ev_out_data);

    if (held_v && ev_out_ready) begin
      exp_q.push_back(held_d);
      held_v = 1'b0;
    end
    if (CW'(pq.size()) > peak) peak = CW'(pq.size());
    if (deq) begin
      k = min_idx();
      held_d = pq[k];
      pq.delete(k);
      held_v = 1'b1; last_disp = held_d; n_deq++; last_enq = 1'b0;
    end
    if (byp) begin
      held_v = 1'b1; held_d = ev_in_data; last_disp = ev_in_data;
      void'(src_q.pop_front());
    end
    if (enq) begin
      if (ev_in_data < last_disp) err_m = 1'b1;
      pq.push_back(ev_in_data);
      n_enq++; last_enq = 1'b1;
      void'(src_q.pop_front());
    end
    if (enq || deq) free = 1'b0;
    else if (q_ready) free = 1'b1;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic reset_checks();
    check_eq("rst_ev_in_ready", DW'(ev_in_ready), '0);
    check_eq("rst_ev_out_valid", DW'(ev_out_valid), '0);
    check_eq("rst_ev_out_data", ev_out_data, '0);
    check_eq("rst_q_enq", DW'(q_enq), '0);
    check_eq("rst_q_deq", DW'(q_deq), '0);
    check_eq("rst_q_inp_data", q_inp_data, '0);
    check_eq("rst_enq_total", DW'(enq_total), '0);
    check_eq("rst_deq_total", DW'(deq_total), '0);
    check_eq("rst_err_causal", DW'(err_causal), '0);
    check_eq("rst_dbg_state", DW'(dbg_state), '0);
  endtask

  // Asserts reset at the current time (asynchronously), checks outputs, then releases on a falling edge
  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    reset_checks();
    model_reset();
    vp = 100; rp = 0; qp = 100;
    ev_in_valid = 1'b0; ev_out_ready = 1'b0; q_ready = 1'b0;
    q_empty = 1'b1; q_full = 1'b0; q_elem_cnt = '0; q_out_data = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    cyc = 0;
    ev_in_valid = 1'b1; q_ready = 1'b1; q_empty = 1'b0;
    #12;
    do_reset();

    // 7, 3, 9 with the consumer stalled: 7 lands in the empty output register first
    src_q = '{32'd7, 32'd3, 32'd9};
    for (int i = 0; i < 20; i++) tick();
    rp = 100;
    for (int i = 0; i < 40 && dut_got.size() < 3; i++) tick();
    check_eq("order_count", DW'(dut_got.size()), DW'(3));
    if (dut_got.size() == 3) begin
      check_eq("order_0", dut_got[0], DW'(7));
      check_eq("order_1", dut_got[1], DW'(3));
      check_eq("order_2", dut_got[2], DW'(9));
    end
    check_eq("order_enq_total", DW'(enq_total), BYP ? DW'(2) : DW'(3));
    check_eq("order_deq_total", DW'(deq_total), BYP ? DW'(2) : DW'(3));

    // Causality: dispatch 50, then an older event must raise the sticky flag
    do_reset();
    rp = 100;
    src_q = '{32'd50};
    for (int i = 0; i < 20 && dut_got.size() < 1; i++) tick();
    check_eq("causal_first_out", DW'(dut_got.size()), DW'(1));
    rp = 0;
    src_q = '{32'd55, 32'd40};
    for (int i = 0; i < 15; i++) tick();
    check_eq("causal_set", DW'(err_causal), DW'(1));
    for (int i = 0; i < 10; i++) tick();
    check_eq("causal_sticky", DW'(err_causal), DW'(1));

    // Queue full: no enqueue for 10 cycles while the producer keeps offering
    do_reset();
    src_q = '{32'd10, 32'd20, 32'd30};
    for (int i = 0; i < 15; i++) tick();
    force_full = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(DW'(100 + i));
    n_enq_seen = 0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("full_no_enq", DW'(n_enq_seen), '0);
    force_full = 1'b0; rp = 100;
    for (int i = 0; i < 200 && !all_idle(); i++) tick();
    check_eq("full_drain", DW'(all_idle()), DW'(1));

    // Continuous producer and consumer: operations alternate with a gap
    do_reset();
    rp = 100;
    for (int i = 0; i < 20; i++) src_q.push_back(DW'(200 + 3 * i));
    for (int i = 0; i < 300 && !all_idle(); i++) tick();
    check_eq("stream_drain", DW'(all_idle()), DW'(1));
    check_eq("stream_count", DW'(dut_got.size()), DW'(20));

    // Latency from acceptance to ev_out_valid with an empty queue
    do_reset();
    src_q = '{32'd5};
    for (int i = 0; i < 10; i++) tick();
    check_eq("latency", DW'(t_val - t_acc), BYP ? DW'(1) : DW'(3));
    check_eq("latency_enq_pulses", DW'(n_enq_seen), BYP ? DW'(0) : DW'(1));
    check_eq("latency_data", ev_out_data, DW'(5));

    // Randomized traffic, then drain and compare the full delivered stream
    do_reset();
    for (int blk = 0; blk < 4; blk++) begin
      vp = $urandom_range(30, 100);
      rp = $urandom_range(20, 100);
      qp = $urandom_range(50, 100);
      for (int i = 0; i < 400; i++) begin
        if (src_q.size() < 4) src_q.push_back(DW'($urandom_range(0, 4095)));
        tick();
      end
    end
    vp = 100; rp = 100; qp = 100;
    for (int i = 0; i < 500 && !all_idle(); i++) tick();
    check_eq("rand_drain", DW'(all_idle()), DW'(1));
    check_eq("rand_stream_len", DW'(dut_got.size()), DW'(exp_q.size()));
    for (int i = 0; i < dut_got.size() && i < exp_q.size(); i++)
      check_eq("rand_stream", dut_got[i], exp_q[i]);

    // Reset in mid-cycle while an event is held: outputs drop without a clock edge
    do_reset();
    src_q = '{32'd77};
    for (int i = 0; i < 30 && !ev_out_valid; i++) tick();
    check_eq("async_held", DW'(ev_out_valid), DW'(1));
    #2;
    do_reset();
    for (int i = 0; i < 5; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
